delay_countdown_timer: RTL

- Downstream stage of the serial 1101 pattern detector; consumes its start_shifting pulse.
- After the pulse, shifts in the next 4 serial bits from the same data_in stream as a delay value D (MSB first).
- Then counts (D+1)*TICKS_PER_UNIT clock cycles, raises done, and holds it until the host acknowledges.
- Returns to IDLE ready for the next detected pattern.

---
 rtl/delay_countdown_timer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/delay_countdown_timer.sv
// ---------------------------------------------------------------------------
// delay_countdown_timer
//
// Purpose:
//   Sits after the serial 1101 pattern detector. When the detector pulses
//   start_shifting, the next DELAY_WIDTH bits of the shared data_in stream
//   are captured MSB first as a delay value D. The block then counts
//   (D+1)*TICKS_PER_UNIT clock cycles and raises done. done stays high until
//   the host acknowledges it, and then the block is ready for the next
//   detected pattern.
//
// Parameters:
//   DELAY_WIDTH    - number of serial delay bits captured (minimum 2)
//   TICKS_PER_UNIT - clock cycles per delay unit, 1 .. 2^16-1
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous reset, active low (0 = in reset)
//   start_shifting in   one-cycle pulse from the pattern detector
//   data_in        in   serial bit stream shared with the pattern detector
//   ack            in   host acknowledge of done
//   shifting       out  high while the delay bits are being captured
//   counting       out  high while the countdown runs
//   done           out  high from the end of the countdown until ack
//   remaining      out  delay units left; valid while counting
// ---------------------------------------------------------------------------
module delay_countdown_timer #(
    parameter int DELAY_WIDTH    = 4,
    parameter int TICKS_PER_UNIT = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_shifting,
    input  logic                   data_in,
    input  logic                   ack,
    output logic                   shifting,
    output logic                   counting,
    output logic                   done,
    output logic [DELAY_WIDTH-1:0] remaining
);

    // A single-unit timer still needs a 1-bit tick counter that never
    // moves off zero, so both counter widths are clamped to at least 1.
    localparam int TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int BIT_W  = (DELAY_WIDTH > 1) ? $clog2(DELAY_WIDTH) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]             state;
    logic [DELAY_WIDTH-2:0] shreg;
    logic [BIT_W-1:0]       bit_cnt;
    logic [TICK_W-1:0]      tick_cnt;
    logic [DELAY_WIDTH-1:0] rem_q;
    logic [DELAY_WIDTH-1:0] captured;

    // The shift register only keeps the bits gathered so far; the final bit
    // arrives on the same edge that loads the countdown, so the full delay
    // value is formed here by appending the live serial input.
    assign captured = {shreg, data_in};

    // Control FSM together with the capture and countdown counters. IDLE
    // clears all working state so a fresh capture never sees leftovers from
    // an earlier run. In COUNT, the tick counter runs 0..TICKS_PER_UNIT-1
    // once per delay unit; the unit that ends with remaining already at zero
    // is the last, which yields exactly (D+1) units of counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            rem_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    shreg    <= '0;
                    bit_cnt  <= '0;
                    tick_cnt <= '0;
                    rem_q    <= '0;
                    if (start_shifting) begin
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    shreg <= captured[DELAY_WIDTH-2:0];
                    if (bit_cnt == BIT_LAST) begin
                        state    <= ST_COUNT;
                        rem_q    <= captured;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end

                ST_COUNT: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (rem_q == '0) begin
                            state <= ST_DONE;
                        end else begin
                            rem_q <= rem_q - DELAY_WIDTH'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end

                ST_DONE: begin
                    if (ack) begin
                        state <= ST_IDLE;
                        rem_q <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, so no input reaches
    // an output without passing through a flop.
    assign shifting  = (state == ST_SHIFT);
    assign counting  = (state == ST_COUNT);
    assign done      = (state == ST_DONE);
    assign remaining = rem_q;

endmodule
